// File: rtl/multiword_addsub_seq_pkg.sv
// rtl/multiword_addsub_seq_pkg.sv - shared constants for the multi-word add/sub sequencer
// Contents: slice width, FSM state codes, index-width helper.
package multiword_addsub_seq_pkg;

  localparam int SLICE_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Word-index width; kept at least 1 bit so a 1-word build still elaborates.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_addsub_seq_if.sv
// rtl/multiword_addsub_seq_if.sv - operand/result bundle between requester and sequencer
// Signals: start, sub, a, b (requester -> sequencer);
//          ready, busy, done, result, cout, v, zero (sequencer -> requester).
// Modports: master = requester side, slave = sequencer side.
interface multiword_addsub_seq_if
  import multiword_addsub_seq_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int N = SLICE_W * WORDS;

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         v;
  logic         zero;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, result, cout, v, zero
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, result, cout, v, zero
  );

endinterface

// File: rtl/multiword_addsub_seq_addsub16_slice.sv
// rtl/multiword_addsub_seq_addsub16_slice.sv - 16-bit gate-level ripple add/sub slice
// Ports: x, y (operands), sub (invert y), cin (carry in);
//        s (sum), cout (carry out of bit 15), c15 (carry into bit 15).
module addsub16_slice
  import multiword_addsub_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               sub,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c15
);

  logic [SLICE_W:0]   w_c;
  logic [SLICE_W-1:0] w_yx;

  assign w_c[0] = cin;

  genvar g;
  generate
    for (g = 0; g < SLICE_W; g++) begin : g_fa
      assign w_yx[g]  = y[g] ^ sub;
      assign s[g]     = x[g] ^ w_yx[g] ^ w_c[g];
      assign w_c[g+1] = (x[g] & w_yx[g]) | (w_c[g] & (x[g] ^ w_yx[g]));
    end
  endgenerate

  assign cout = w_c[SLICE_W];
  assign c15  = w_c[SLICE_W-1];

endmodule

// File: rtl/multiword_addsub_seq.sv
// rtl/multiword_addsub_seq.sv - WORDS x 16-bit add/sub by time-sharing one 16-bit slice
// Ports: clk, rst (async, active-high);
//        bus (slave): start/sub/a/b in; ready/busy/done/result/cout/v/zero out.
module multiword_addsub_seq
  import multiword_addsub_seq_pkg::*;
#(
  parameter int WORDS = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  multiword_addsub_seq_if.slave bus
);

  localparam int                N        = SLICE_W * WORDS;
  localparam int                IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_sub;
  logic [SLICE_W-1:0] r_a_w   [WORDS];
  logic [SLICE_W-1:0] r_b_w   [WORDS];
  logic [SLICE_W-1:0] r_res_w [WORDS];
  logic               r_cout;
  logic               r_v;
  logic               r_zero;

  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic               w_c15;
  logic               w_low_zero;
  logic [N-1:0]       w_result;

  addsub16_slice u_slice (
    .x    (r_a_w[r_idx]),
    .y    (r_b_w[r_idx]),
    .sub  (r_sub),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .c15  (w_c15)
  );

  // Only consulted on the last pass, so words below WORDS-1 are already final.
  always_comb begin
    w_low_zero = 1'b1;
    for (int i = 0; i < WORDS - 1; i++) begin
      if (r_res_w[i] != '0) w_low_zero = 1'b0;
    end
  end

  always_comb begin
    w_result = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_result[i*SLICE_W +: SLICE_W] = r_res_w[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_zero  <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_a_w[i]   <= '0;
        r_b_w[i]   <= '0;
        r_res_w[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < WORDS; i++) begin
              r_a_w[i] <= bus.a[i*SLICE_W +: SLICE_W];
              r_b_w[i] <= bus.b[i*SLICE_W +: SLICE_W];
            end
            r_sub   <= bus.sub;
            r_idx   <= '0;
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_carry <= bus.sub;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res_w[r_idx] <= w_s;
          r_carry        <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_v     <= w_cout ^ w_c15;
            r_zero  <= (w_s == '0) && w_low_zero;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready  = (r_state == S_IDLE);
  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = w_result;
  assign bus.cout   = r_cout;
  assign bus.v      = r_v;
  assign bus.zero   = r_zero;

endmodule

// File: doc/multiword_addsub_seq.md
Name: multiword_addsub_seq

Overview:
- Sequencer that performs WORDS×16-bit two's-complement add/subtract by time-sharing one 16-bit add/sub ripple slice.
- Processes one 16-bit word per cycle, LSW first, chaining the carry between passes.
- Reports carry/borrow, signed overflow and zero flags.
- Sits between the register file and the 16-bit adder datapath, serving wide operands (default 64-bit).

Parameters:
- WORDS, 4, number of 16-bit words per operand (2..8); operand width N = 16*WORDS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when ready=1.
- sub  in  1  0 = a+b, 1 = a-b; latched at accept.
- a  in  N  operand A; latched at accept.
- b  in  N  operand B; latched at accept.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- result  out  N  sum/difference.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- v  out  1  signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, carry=0, operand regs=0, result=0, cout=0, v=0, zero=0, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b, sub; idx<=0; carry<=sub; go to RUN. Otherwise hold all outputs.
- RUN, each cycle:
  - Slice computes s = a_w[idx] + (b_w[idx] XOR {16{sub}}) + carry.
  - result word idx <= s; carry <= slice cout.
  - If idx == WORDS-1: cout <= slice cout; v <= slice cout XOR carry into slice bit 15; zero <= (new full result == 0); go to DONE.
  - Else idx <= idx+1.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency: start sampled at edge E0. Words computed at edges E1..E_WORDS. done is high in the cycle following E_WORDS (WORDS+1 edges after accept; 5 for the default).
- Outputs result, cout, v, zero:
  - Valid from the done cycle onward.
  - Held until the next accepted start.
  - result words update progressively during RUN and are not valid then.
- start while busy or in DONE is ignored and not queued; no error flag.
- sub is applied uniformly: B inverted in every word, initial carry = sub.
- Reset asserted mid-RUN aborts the operation: no done pulse, all outputs at reset values, ready=1 at the first edge after reset release.
- Widths: operands and result are unsigned bit vectors. Signed interpretation applies only to v. No saturation; result wraps modulo 2^N.

Decomposition:
- Shared package: SLICE_W=16; state encoding enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2); index width constant clog2(WORDS).
- Sub-module addsub16_slice:
  - Ports: x[16], y[16], sub, cin; s[16], cout, c15 (carry into bit 15).
  - Gate-level ripple of 16 full adders with internal y XOR sub.
  - The sequencer instantiates it once.
- FSM, index counter, operand word mux and result write-back live in multiword_addsub_seq.

Test Plan:
- Add 0x0000_0000_0000_FFFF + 0x1 -> result 0x0000_0000_0001_0000, cout=0, v=0, zero=0; done exactly 5 cycles after start accepted, busy high for 4 cycles.
- Sub 0x0 - 0x1 -> result 0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow), v=0, zero=0.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> result 0x8000_0000_0000_0000, v=1, cout=0; Add 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 -> result 0, v=1, cout=1, zero=1.
- Sub 0x1234_5678_9ABC_DEF0 - same -> result 0, zero=1, cout=1, v=0.
- start re-asserted during RUN and during the done cycle -> ignored, single done pulse, result unchanged; start on the cycle after done -> accepted.
- rst pulsed during 2nd RUN cycle of an add -> ready=1, busy=0, result=0, flags=0, no done pulse; next operation 0x1+0x2 completes correctly with result 0x3.
